// File: rtl/fpadd_driver.sv
// ============================================================================
// Module  : fpadd_driver
// Brief   : Serial-operand initiator for fpadder with a result FIFO.
//           Optional tag path is enabled by defining FPADD_DRIVER_TAG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpadd_driver #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 4
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [31:0]       op_m,
  input  logic [31:0]       op_n,
`ifdef FPADD_DRIVER_TAG_EN
  input  logic [TAG_W-1:0]  op_tag,
  output logic [TAG_W-1:0]  res_tag,
`endif
  output logic [31:0]       fp_a,
  input  logic [31:0]       fp_sum,
  input  logic              fp_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_sum,
  output logic              busy,
  output logic              err_timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
`ifdef FPADD_DRIVER_TAG_EN
  localparam int TAG_EN = 1;
`else
  localparam int TAG_EN = 0;
`endif
  localparam int ENTRY_W = 32 + TAG_EN * TAG_W;

  localparam logic [1:0] S_LOAD_M = 2'd0;
  localparam logic [1:0] S_LOAD_N = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [31:0]        fp_a_q, n_q;
  logic               busy_q, err_q;
  logic [WD_W-1:0]    wdog_q;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               ready_edge, push, pop, accept;
  logic [ENTRY_W-1:0] push_entry, head;
`ifdef FPADD_DRIVER_TAG_EN
  logic [TAG_W-1:0]   tag_q;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state_q <= S_LOAD_M;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD_M: state_d = S_LOAD_N;
      S_LOAD_N: state_d = S_WAIT;
      S_WAIT:   if (fp_ready) state_d = S_LOAD_M;
      default:  state_d = S_LOAD_M;
    endcase
  end

  // A pair is only accepted when a FIFO slot is guaranteed; a same-cycle pop is not credited.
  always_comb begin
    ready_edge = (state_q == S_WAIT) && fp_ready;
    push       = ready_edge && busy_q;
    op_ready   = ready_edge && ((int'(count_q) + int'(push)) < DEPTH);
    accept     = op_valid && op_ready;
    pop        = (count_q != '0) && res_ready;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      fp_a_q <= '0;
      n_q    <= '0;
      busy_q <= 1'b0;
      wdog_q <= '0;
      err_q  <= 1'b0;
`ifdef FPADD_DRIVER_TAG_EN
      tag_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_LOAD_M: fp_a_q <= n_q;
        S_LOAD_N: begin
          fp_a_q <= '0;
          wdog_q <= '0;
        end
        S_WAIT: begin
          if (fp_ready) begin
            fp_a_q <= accept ? op_m : 32'd0;
            n_q    <= accept ? op_n : 32'd0;
            busy_q <= accept;
`ifdef FPADD_DRIVER_TAG_EN
            if (accept) tag_q <= op_tag;
`endif
          end else begin
            if (wdog_q != WD_W'(TIMEOUT_CYCLES)) wdog_q <= wdog_q + WD_W'(1);
            if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) err_q <= 1'b1;
          end
        end
        default: fp_a_q <= '0;
      endcase
    end
  end

`ifdef FPADD_DRIVER_TAG_EN
  assign push_entry = {tag_q, fp_sum};
`else
  assign push_entry = fp_sum;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign res_valid   = (count_q != '0);
  assign res_sum     = res_valid ? head[31:0] : 32'd0;
`ifdef FPADD_DRIVER_TAG_EN
  assign res_tag     = res_valid ? head[ENTRY_W-1:32] : '0;
`endif
  assign fp_a        = fp_a_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fpadd_driver.sv
// ============================================================================
// Module  : tb_fpadd_driver
// Brief   : Self-checking bench for fpadd_driver with a behavioural fpadder model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fpadd_driver;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             nreset = 1'b0;
  logic             op_valid = 1'b0, op_ready;
  logic [31:0]      op_m = '0, op_n = '0;
  logic [TAG_W-1:0] op_tag = '0;
  logic [31:0]      fp_a, fp_sum = '0;
  logic             fp_ready = 1'b0;
  logic             res_valid, res_ready = 1'b0, busy, err_timeout;
  logic [31:0]      res_sum;
`ifdef FPADD_DRIVER_TAG_EN
  logic [TAG_W-1:0] res_tag;
`endif

  fpadd_driver #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .TAG_W(TAG_W)) dut (
    .clock(clock), .nreset(nreset),
    .op_valid(op_valid), .op_ready(op_ready), .op_m(op_m), .op_n(op_n),
`ifdef FPADD_DRIVER_TAG_EN
    .op_tag(op_tag), .res_tag(res_tag),
`endif
    .fp_a(fp_a), .fp_sum(fp_sum), .fp_ready(fp_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Stand-in for the adder arithmetic: exact IEEE sums for the known vectors, a fixed mix otherwise.
  function automatic logic [31:0] add_fn(input logic [31:0] m, input logic [31:0] n);
    case ({m, n})
      {32'h3f800000, 32'h3f800000}: return 32'h40000000;
      {32'h42280000, 32'h40490fd0}: return 32'h423490fd;
      {32'hbf800000, 32'h3f800000}: return 32'h00000000;
      {32'h00000000, 32'h00000000}: return 32'h00000000;
      default:                      return (m + {n[15:0], n[31:16]}) ^ 32'h5a5a0001;
    endcase
  endfunction

  // fpadder model: samples m, then n, computes for a random latency, strobes ready once.
  int          phase = 0, cnt = 0, max_lat = 3;
  logic [31:0] am = '0, an = '0;
  bit          hold_ready = 0, glitch_en = 0;

  always @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      phase = 0; cnt = 0; fp_ready = 1'b0; fp_sum = '0;
    end else begin
      case (phase)
        0: begin am = fp_a; phase = 1; end
        1: begin an = fp_a; cnt = $urandom_range(max_lat, 0); phase = 2; end
        default: if (fp_ready) phase = 0; else if (cnt > 0) cnt--;
      endcase
      #1;
      fp_ready = (phase == 2 && cnt == 0 && !hold_ready) ||
                 (phase == 1 && glitch_en && $urandom_range(3, 0) == 0);
      fp_sum   = (phase == 2 && fp_ready) ? add_fn(am, an) : 32'hdeadbeef;
    end
  end

  // Reference model: accepted ops in flight, then results waiting for the consumer.
  logic [63:0] infl_q[$];
  logic [63:0] fifo_q[$];
  int          wait_cnt = 0;
  bit          err_exp = 0, mon_en = 0;

  always @(negedge clock) begin
    if (nreset && mon_en) begin
      bit          exp_rdy;
      logic [63:0] e;
      exp_rdy = (phase == 2) && fp_ready && ((fifo_q.size() + infl_q.size()) < DEPTH);
      check("res_valid", 64'(res_valid), 64'(fifo_q.size() != 0));
      if (fifo_q.size() != 0) begin
        check("res_sum", 64'(res_sum), 64'(fifo_q[0][31:0]));
`ifdef FPADD_DRIVER_TAG_EN
        check("res_tag", 64'(res_tag), 64'(fifo_q[0][32 +: TAG_W]));
`endif
      end
      check("busy", 64'(busy), 64'(infl_q.size() != 0));
      check("op_ready", 64'(op_ready), 64'(exp_rdy));
      check("err_timeout", 64'(err_timeout), 64'(err_exp));
      if (res_ready && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (phase == 2 && fp_ready && infl_q.size() != 0) fifo_q.push_back(infl_q.pop_front());
      if (op_valid && exp_rdy) begin
        e = {32'd0, add_fn(op_m, op_n)};
        e[32 +: TAG_W] = op_tag;
        infl_q.push_back(e);
      end
      if (phase == 2 && !fp_ready) begin
        wait_cnt++;
        if (wait_cnt >= TMO) err_exp = 1;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  typedef struct {
    logic [31:0] m;
    logic [31:0] n;
    logic [31:0] sum;
  } vec_t;

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [31:0] m, input logic [31:0] n);
    bit got = 0;
    op_valid = 1'b1; op_m = m; op_n = n; op_tag = TAG_W'($urandom);
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clock); got = op_ready;
      step();
    end
    op_valid = 1'b0;
    check("send_accept", 64'(got), 64'(1));
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clock);
      ok = (busy == 1'b0) && (infl_q.size() == 0);
    end
    check(name, 64'(ok), 64'(1));
    step();
  endtask

  task automatic pop_one();
    res_ready = 1'b1; step(); res_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_fp_a"}, 64'(fp_a), 64'(0));
    check({name, "_op_ready"}, 64'(op_ready), 64'(0));
    check({name, "_res_valid"}, 64'(res_valid), 64'(0));
    check({name, "_res_sum"}, 64'(res_sum), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_err"}, 64'(err_timeout), 64'(0));
`ifdef FPADD_DRIVER_TAG_EN
    check({name, "_res_tag"}, 64'(res_tag), 64'(0));
`endif
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t vecs[3];
    int   acc;
    bit   ok, a;

    vecs[0] = '{32'h3f800000, 32'h3f800000, 32'h40000000};
    vecs[1] = '{32'h42280000, 32'h40490fd0, 32'h423490fd};
    vecs[2] = '{32'hbf800000, 32'h3f800000, 32'h00000000};

    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    @(negedge clock);
    nreset = 1'b1; mon_en = 1;
    step();

    // Known vectors back to back, fp_a sequence checked, results popped in order.
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].m, vecs[i].n);
      check("fp_a_m", 64'(fp_a), 64'(vecs[i].m));
      step();
      check("fp_a_n", 64'(fp_a), 64'(vecs[i].n));
    end
    wait_idle("vec_busy_fall");
    check("vec_busy_low", 64'(busy), 64'(0));
    for (int i = 0; i < 3; i++) begin
      check("vec_res_valid", 64'(res_valid), 64'(1));
      check("vec_res_sum", 64'(res_sum), 64'(vecs[i].sum));
      pop_one();
    end

    // No pairs offered: only dummies, nothing on the bus, nothing pushed.
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      check("idle_fp_a", 64'(fp_a), 64'(0));
      check("idle_res_valid", 64'(res_valid), 64'(0));
    end
    step();

    // Consumer stalled: exactly DEPTH pairs fit, then the rest go once popping resumes.
    acc = 0;
    op_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock); if (op_ready) acc++;
      step();
      op_m = $urandom; op_n = $urandom; op_tag = TAG_W'($urandom);
    end
    check("bp_accepts_full", 64'(acc), 64'(DEPTH));
    check("bp_res_valid", 64'(res_valid), 64'(1));
    res_ready = 1'b1;
    for (int c = 0; c < 200 && acc < DEPTH + 2; c++) begin
      @(negedge clock); if (op_ready) acc++;
      step();
      op_m = $urandom; op_n = $urandom; op_tag = TAG_W'($urandom);
    end
    op_valid = 1'b0;
    check("bp_accepts_total", 64'(acc), 64'(DEPTH + 2));
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clock); ok = (fifo_q.size() == 0) && (infl_q.size() == 0);
    end
    check("bp_drained", 64'(ok), 64'(1));
    step();
    res_ready = 1'b0;

    // Adder stalls in WAIT: watchdog trips and sticks, the late result still lands.
    send(32'h3f800000, 32'h3f800000);
    @(negedge clock); hold_ready = 1;
    repeat (10) @(negedge clock);
    check("wd_early_err", 64'(err_timeout), 64'(0));
    repeat (TMO) @(negedge clock);
    check("wd_err_set", 64'(err_timeout), 64'(1));
    check("wd_busy", 64'(busy), 64'(1));
    check("wd_no_result", 64'(res_valid), 64'(0));
    hold_ready = 0;
    wait_idle("wd_late_ready");
    check("wd_late_valid", 64'(res_valid), 64'(1));
    check("wd_late_sum", 64'(res_sum), 64'(32'h40000000));
    check("wd_err_sticky", 64'(err_timeout), 64'(1));
    pop_one();

    // Asynchronous reset while in LOAD_N with two results queued.
    send(vecs[1].m, vecs[1].n);
    send(vecs[2].m, vecs[2].n);
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clock); ok = (fifo_q.size() == 2) && (phase == 1);
      if (ok) nreset = 1'b0;
    end
    check("rst_reached_load_n", 64'(ok), 64'(1));
    nreset = 1'b0;
    #1;
    check_reset_values("midrst");
    infl_q.delete(); fifo_q.delete(); err_exp = 0; wait_cnt = 0;
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    repeat (8) begin
      @(negedge clock);
      check("post_rst_empty", 64'(res_valid), 64'(0));
    end
    step();

    // Random traffic against the reference model.
    glitch_en = 1;
    a = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock); a = op_valid && op_ready;
      step();
      if (!op_valid || a) begin
        op_valid = ($urandom_range(2, 0) != 0);
        op_m = $urandom; op_n = $urandom; op_tag = TAG_W'($urandom);
      end
      res_ready = ($urandom_range(2, 0) != 0);
    end
    op_valid = 1'b0; glitch_en = 0; res_ready = 1'b1;
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clock); ok = (fifo_q.size() == 0) && (infl_q.size() == 0);
    end
    check("rand_drained", 64'(ok), 64'(1));
    check("rand_res_valid_low", 64'(res_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
